// File: rtl/bcd_stopwatch.sv
`default_nettype none
// ============================================================================
// Module      : bcd_stopwatch
// Description : Clock-enable prescaler driving an N-digit BCD up/down counter
//               with synchronous clear, clamped parallel load, full-range wrap
//               flag and a lap (display freeze) snapshot.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_stopwatch #(
  parameter int CLK_DIV = 1_000_000,
  parameter int DIGITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick,
  output logic                  wrap,
  output logic                  lap_active
);

  localparam int            PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int            CW         = 4 * DIGITS;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] live_q,  live_d;
  logic [CW-1:0] snap_q,  snap_d;
  logic          tick_q,  tick_d;
  logic          wrap_q,  wrap_d;
  logic          lap_q,   lap_d;

  logic          step;
  logic [CW-1:0] stepped;
  logic          live_wrap;
  logic [CW-1:0] load_clamped;

  // A step happens on the edge where the running prescaler sits at its last value
  assign step = en && (presc_q == PRESC_LAST);

  // Ripple carry/borrow through the digits; a carry out of the top digit is a wrap
  always_comb begin
    logic carry;
    carry     = 1'b1;
    stepped   = live_q;
    live_wrap = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!carry) begin
        stepped[4*i +: 4] = live_q[4*i +: 4];
      end else if (up) begin
        if (live_q[4*i +: 4] >= 4'd9) begin
          stepped[4*i +: 4] = 4'd0;
          carry             = 1'b1;
        end else begin
          stepped[4*i +: 4] = live_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end else begin
        if (live_q[4*i +: 4] == 4'd0) begin
          stepped[4*i +: 4] = 4'd9;
          carry             = 1'b1;
        end else begin
          stepped[4*i +: 4] = live_q[4*i +: 4] - 4'd1;
          carry             = 1'b0;
        end
      end
    end
    live_wrap = carry;
  end

  // Non-BCD load nibbles saturate at 9 so the live value is always valid BCD
  always_comb begin
    load_clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      load_clamped[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end
  end

  // Next-state selection: clr beats load beats step; lap runs alongside load/step
  always_comb begin
    presc_d = presc_q;
    live_d  = live_q;
    snap_d  = snap_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    lap_d   = lap_q;
    if (clr) begin
      presc_d = '0;
      live_d  = '0;
      snap_d  = '0;
      lap_d   = 1'b0;
    end else begin
      // Snapshot captures the pre-step live value even if a step lands on this edge
      if (lap) begin
        lap_d = ~lap_q;
        if (!lap_q) begin
          snap_d = live_q;
        end
      end
      if (load) begin
        presc_d = '0;
        live_d  = load_clamped;
      end else if (en) begin
        presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        if (step) begin
          live_d = stepped;
          tick_d = 1'b1;
          wrap_d = live_wrap;
        end
      end
    end
  end

  // State and registered pulse outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      live_q  <= '0;
      snap_q  <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      lap_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      live_q  <= live_d;
      snap_q  <= snap_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      lap_q   <= lap_d;
    end
  end

  assign count      = lap_q ? snap_q : live_q;
  assign tick       = tick_q;
  assign wrap       = wrap_q;
  assign lap_active = lap_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_stopwatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_stopwatch
// Description : Scoreboard bench for bcd_stopwatch (CLK_DIV=4, DIGITS=2).
//               Stimulus pushes the expected displayed value for each step;
//               a monitor pops and compares whenever tick is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_stopwatch;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       clr;
  logic       load;
  logic [7:0] load_val;
  logic       lap;
  logic [7:0] count;
  logic       tick;
  logic       wrap;
  logic       lap_active;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] cnt;
    logic       wr;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  bcd_stopwatch #(.CLK_DIV(4), .DIGITS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .up         (up),
    .clr        (clr),
    .load       (load),
    .load_val   (load_val),
    .lap        (lap),
    .count      (count),
    .tick       (tick),
    .wrap       (wrap),
    .lap_active (lap_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] c, input logic w, input string nm);
    exp_t e;
    e.cnt = c;
    e.wr  = w;
    e.nm  = nm;
    exp_q.push_back(e);
  endtask

  task automatic step_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // tick must stay low for n-1 edges and be high after the n-th
  task automatic expect_tick_after(input int n, input string nm);
    for (int k = 1; k < n; k++) begin
      step_edges(1);
      chk({nm, "_idle"}, {31'd0, tick}, 32'd0);
    end
    step_edges(1);
    chk({nm, "_tick"}, {31'd0, tick}, 32'd1);
  endtask

  function automatic logic [7:0] dec2bcd(input int v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'((v / 10) % 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  // Monitor: every presented tick consumes one expected step
  always @(negedge clk) begin
    if (!rst && tick) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_tick: count=%0h wrap=%0b, expected no step", count, wrap);
      end else begin
        mon_e = exp_q.pop_front();
        chk({mon_e.nm, "_count"}, {24'd0, count}, {24'd0, mon_e.cnt});
        chk({mon_e.nm, "_wrap"}, {31'd0, wrap}, {31'd0, mon_e.wr});
      end
    end
    if (!rst && wrap && !tick) begin
      n_tests++;
      n_fail++;
      $display("FAIL wrap_without_tick: wrap=1 tick=0, expected wrap only with tick");
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0;
    load_val = 8'h00; lap = 1'b0;
    step_edges(2);
    chk("rst_count", {24'd0, count}, 32'h00);
    chk("rst_tick", {31'd0, tick}, 32'd0);
    chk("rst_lap", {31'd0, lap_active}, 32'd0);

    // ---- 1: reset release, first ticks, async reset mid-count
    rst = 1'b0; en = 1'b1; up = 1'b1;
    push_exp(8'h01, 1'b0, "first_step");
    expect_tick_after(4, "first_step");
    push_exp(8'h02, 1'b0, "second_step");
    expect_tick_after(4, "second_step");
    lap = 1'b1;
    step_edges(1);
    lap = 1'b0;
    chk("lap_on_flag", {31'd0, lap_active}, 32'd1);
    chk("lap_on_count", {24'd0, count}, 32'h02);
    step_edges(1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", {24'd0, count}, 32'h00);
    chk("async_rst_tick", {31'd0, tick}, 32'd0);
    chk("async_rst_wrap", {31'd0, wrap}, 32'd0);
    chk("async_rst_lap", {31'd0, lap_active}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    push_exp(8'h01, 1'b0, "post_rst_step");
    expect_tick_after(4, "post_rst_step");

    // ---- 2: count up with carry, then 99 -> 00 wrap
    clr = 1'b1;
    step_edges(1);
    clr = 1'b0;
    chk("clr_count", {24'd0, count}, 32'h00);
    for (int k = 1; k <= 10; k++) push_exp(dec2bcd(k), 1'b0, "up_run");
    step_edges(36);
    chk("up_at_09", {24'd0, count}, 32'h09);
    step_edges(4);
    chk("up_carry_10", {24'd0, count}, 32'h10);
    load_val = 8'h98; load = 1'b1;
    step_edges(1);
    load = 1'b0;
    chk("load_98", {24'd0, count}, 32'h98);
    push_exp(8'h99, 1'b0, "to_99");
    push_exp(8'h00, 1'b1, "up_wrap");
    push_exp(8'h01, 1'b0, "after_wrap");
    step_edges(4);
    chk("at_99", {24'd0, count}, 32'h99);
    step_edges(4);
    chk("wrap_count", {24'd0, count}, 32'h00);
    chk("wrap_tick", {31'd0, tick}, 32'd1);
    chk("wrap_flag", {31'd0, wrap}, 32'd1);
    step_edges(1);
    chk("wrap_one_cycle", {31'd0, wrap}, 32'd0);
    chk("tick_one_cycle", {31'd0, tick}, 32'd0);
    step_edges(3);
    chk("after_wrap_01", {24'd0, count}, 32'h01);

    // ---- 3: count down, underflow wrap and borrow
    clr = 1'b1;
    step_edges(1);
    clr = 1'b0; up = 1'b0;
    chk("down_start", {24'd0, count}, 32'h00);
    push_exp(8'h99, 1'b1, "down_wrap");
    step_edges(4);
    chk("down_wrap_count", {24'd0, count}, 32'h99);
    chk("down_wrap_flag", {31'd0, wrap}, 32'd1);
    load_val = 8'h10; load = 1'b1;
    step_edges(1);
    load = 1'b0;
    push_exp(8'h09, 1'b0, "borrow");
    step_edges(4);
    chk("borrow_09", {24'd0, count}, 32'h09);

    // ---- 4: clamped load restarts prescaler; clr beats load
    up = 1'b1;
    step_edges(2);
    load_val = 8'h5C; load = 1'b1;
    step_edges(1);
    load = 1'b0;
    chk("load_clamp", {24'd0, count}, 32'h59);
    chk("load_no_tick", {31'd0, tick}, 32'd0);
    push_exp(8'h60, 1'b0, "load_restart");
    expect_tick_after(4, "load_restart");
    clr = 1'b1; load = 1'b1; load_val = 8'h42;
    step_edges(1);
    clr = 1'b0; load = 1'b0;
    chk("clr_over_load", {24'd0, count}, 32'h00);
    chk("clr_over_load_tick", {31'd0, tick}, 32'd0);

    // ---- 5: lap coincident with a step, release after three steps
    load_val = 8'h37; load = 1'b1;
    step_edges(1);
    load = 1'b0;
    chk("lap_load_37", {24'd0, count}, 32'h37);
    push_exp(8'h37, 1'b0, "lap_frozen");
    push_exp(8'h37, 1'b0, "lap_frozen");
    push_exp(8'h37, 1'b0, "lap_frozen");
    step_edges(3);
    lap = 1'b1;
    step_edges(1);
    lap = 1'b0;
    chk("lap_step_flag", {31'd0, lap_active}, 32'd1);
    chk("lap_step_count", {24'd0, count}, 32'h37);
    chk("lap_step_tick", {31'd0, tick}, 32'd1);
    step_edges(8);
    chk("lap_still_37", {24'd0, count}, 32'h37);
    lap = 1'b1;
    step_edges(1);
    lap = 1'b0;
    chk("lap_off_flag", {31'd0, lap_active}, 32'd0);
    chk("lap_off_live", {24'd0, count}, 32'h40);
    push_exp(8'h41, 1'b0, "post_lap");
    step_edges(3);
    chk("post_lap_41", {24'd0, count}, 32'h41);

    // ---- 6: en dropped mid-period, remaining cycles complete after re-enable
    step_edges(2);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step_edges(1);
      chk("en_low_no_tick", {31'd0, tick}, 32'd0);
    end
    chk("en_low_hold", {24'd0, count}, 32'h41);
    en = 1'b1;
    push_exp(8'h42, 1'b0, "resume");
    expect_tick_after(2, "resume");
    en = 1'b0;
    step_edges(2);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
